tag_set_array: RTL

TAG_SET_ARRAY -- requirements
Module: tag_set_array

---
 rtl/tag_set_array.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tag_set_array.sv
// tag_set_array: set-associative tag/valid store with round-robin victim
// pointers, single-cycle lookup response and a one-set-per-cycle flush sweep.
// Optional feature macro: TAG_PARITY_EN (even parity per stored tag).
module tag_set_array #(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 10,
    parameter int TAG_BITS = 37
) (
    input  logic                     clk,
    input  logic                     gen_reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [SET_BITS-1:0]      req_set,
    input  logic [TAG_BITS-1:0]      req_tag,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [$clog2(WAYS)-1:0]  resp_way,
    input  logic                     fill_en,
    input  logic [SET_BITS-1:0]      fill_set,
    input  logic [$clog2(WAYS)-1:0]  fill_way,
    input  logic [TAG_BITS-1:0]      fill_tag,
    input  logic                     flush_req,
    output logic                     busy,
    output logic                     flush_done,
    output logic                     parity_err
);
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int SETS     = 2 ** SET_BITS;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                state, state_next;
    logic [SET_BITS-1:0]   flush_set, flush_set_next;
    logic                  flush_done_next;

    logic [TAG_BITS-1:0]   tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]       valid_mem [SETS];
    logic [WAY_BITS-1:0]   ptr_mem   [SETS];

    logic                  accept;
    logic                  fill_ok;
    logic [WAYS-1:0]       valid_row;
    logic [WAYS-1:0]       par_bad;
    logic [WAYS-1:0]       eff_valid;
    logic                  hit_p0;
    logic [WAY_BITS-1:0]   hit_way_p0;
    logic                  inv_found_p0;
    logic [WAY_BITS-1:0]   inv_way_p0;

    assign req_ready = (state == IDLE) & ~gen_reset;
    assign busy      = (state == FLUSH);
    assign accept    = req_valid & req_ready;
    assign fill_ok   = fill_en & (state == IDLE) & ~gen_reset;
    assign valid_row = valid_mem[req_set];
    assign eff_valid = valid_row & ~par_bad;

    // FSM state register: reset forces a fresh sweep from set 0
    always_ff @(posedge clk) begin
        if (gen_reset) begin
            state      <= FLUSH;
            flush_set  <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_next;
            flush_set  <= flush_set_next;
            flush_done <= flush_done_next;
        end
    end

    // FSM next state: a sweep visits every set once, then returns to IDLE
    always_comb begin
        state_next      = state;
        flush_set_next  = flush_set;
        flush_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_next     = FLUSH;
                    flush_set_next = '0;
                end
            end
            FLUSH: begin
                flush_set_next = flush_set + 1'b1;
                if (flush_set == {SET_BITS{1'b1}}) begin
                    state_next      = IDLE;
                    flush_done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Tag storage is never reset; fills only land while IDLE
    always_ff @(posedge clk) begin
        if (fill_ok) begin
            tag_mem[fill_set][fill_way] <= fill_tag;
        end
    end

    // Valid bits and victim pointers: cleared by the sweep, set by fills
    always_ff @(posedge clk) begin
        if (state == FLUSH && !gen_reset) begin
            valid_mem[flush_set] <= '0;
            ptr_mem[flush_set]   <= '0;
        end else if (fill_ok) begin
            valid_mem[fill_set][fill_way] <= 1'b1;
            ptr_mem[fill_set]             <= fill_way + 1'b1;
        end
    end

`ifdef TAG_PARITY_EN
    logic [WAYS-1:0] par_mem [SETS];
    logic [WAYS-1:0] par_ok;

    function automatic logic even_parity(input logic [TAG_BITS-1:0] tag);
        return ^tag;
    endfunction

    // Parity bit travels with the tag on every fill
    always_ff @(posedge clk) begin
        if (fill_ok) begin
            par_mem[fill_set][fill_way] <= even_parity(fill_tag);
        end
    end

    // Recompute parity of the addressed row for comparison with stored bits
    always_comb begin
        par_ok = '0;
        for (int w = 0; w < WAYS; w++) begin
            par_ok[w] = (even_parity(tag_mem[req_set][w]) == par_mem[req_set][w]);
        end
    end

    assign par_bad = valid_row & ~par_ok;

    // Parity error pulses alongside the response it affected
    always_ff @(posedge clk) begin
        if (gen_reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= accept & (|par_bad);
        end
    end
`else
    assign par_bad    = '0;
    assign parity_err = 1'b0;
`endif

    // Lookup compare: lowest matching valid way wins, lowest invalid way is the preferred victim
    always_comb begin
        hit_p0       = 1'b0;
        hit_way_p0   = '0;
        inv_found_p0 = 1'b0;
        inv_way_p0   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (eff_valid[w] && !hit_p0 && tag_mem[req_set][w] == req_tag) begin
                hit_p0     = 1'b1;
                hit_way_p0 = WAY_BITS'(w);
            end
            if (!eff_valid[w] && !inv_found_p0) begin
                inv_found_p0 = 1'b1;
                inv_way_p0   = WAY_BITS'(w);
            end
        end
    end

    // Response register: storage is read before any same-cycle fill or sweep lands
    always_ff @(posedge clk) begin
        if (gen_reset) begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_way   <= '0;
        end else begin
            resp_valid <= accept;
            if (accept) begin
                resp_hit <= hit_p0;
                if (hit_p0) begin
                    resp_way <= hit_way_p0;
                end else if (inv_found_p0) begin
                    resp_way <= inv_way_p0;
                end else begin
                    resp_way <= ptr_mem[req_set];
                end
            end
        end
    end
endmodule
